// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and five-phase strobe generator for the
// instruction-fetch side of the processor. The PC is presented as the
// instruction-memory address and only moves at the edge that ends p5.
module fetch_sequencer #(
    parameter int                   PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                exec,
    input  logic                halt_req,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc_to_memory,
    output logic [PC_WIDTH-1:0] pc_plus_one,
    output logic                p1,
    output logic                p2,
    output logic                p3,
    output logic                p4,
    output logic                p5,
    output logic                running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_1    = 5'b00001;
    localparam logic [4:0] PH_2    = 5'b00010;
    localparam logic [4:0] PH_3    = 5'b00100;
    localparam logic [4:0] PH_4    = 5'b01000;
    localparam logic [4:0] PH_5    = 5'b10000;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    logic [4:0]          phase;
    logic [PC_WIDTH-1:0] pc;

    // Sequencer: IDLE waits for exec, RUN rotates the one-hot phase and
    // resolves next-PC / halt at the end of p5.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            phase <= PH_NONE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    phase <= PH_NONE;
                    if (exec) begin
                        state <= RUN;
                        phase <= PH_1;
                    end
                end
                RUN: begin
                    case (phase)
                        PH_1: phase <= PH_2;
                        PH_2: phase <= PH_3;
                        PH_3: phase <= PH_4;
                        PH_4: phase <= PH_5;
                        PH_5: begin
                            // PC always advances, even on halt, so a
                            // restart fetches the following instruction.
                            if (branch_taken) begin
                                pc <= branch_target;
                            end else begin
                                pc <= pc + PC_ONE;
                            end
                            if (halt_req) begin
                                state <= IDLE;
                                phase <= PH_NONE;
                            end else begin
                                phase <= PH_1;
                            end
                        end
                        // Corrupted one-hot pattern: resynchronise to p1.
                        default: phase <= PH_1;
                    endcase
                end
                default: begin
                    state <= IDLE;
                    phase <= PH_NONE;
                end
            endcase
        end
    end

    // Strobes and running come straight from registers; only the link
    // value is combinational.
    always_comb begin
        p1           = phase[0];
        p2           = phase[1];
        p3           = phase[2];
        p4           = phase[3];
        p5           = phase[4];
        running      = (state == RUN);
        pc_to_memory = pc;
        pc_plus_one  = pc + PC_ONE;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed walk through the fetch behaviour
// followed by random traffic, checked cycle by cycle against an
// instruction-level model (running flag, phase number 1..5, PC).
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        exec;
  logic        halt_req;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc_to_memory;
  logic [15:0] pc_plus_one;
  logic        p1, p2, p3, p4, p5;
  logic        running;

  int checks   = 0;
  int failures = 0;

  // model state
  bit          m_run;
  int          m_ph;
  logic [15:0] m_pc;

  fetch_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .exec          (exec),
    .halt_req      (halt_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_to_memory  (pc_to_memory),
    .pc_plus_one   (pc_plus_one),
    .p1            (p1),
    .p2            (p2),
    .p3            (p3),
    .p4            (p4),
    .p5            (p5),
    .running       (running)
  );

  // clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_run = 1'b0;
    m_ph  = 0;
    m_pc  = 16'h0000;
  endtask

  task automatic check(input string tag);
    logic [4:0]  exp_strobes;
    logic [4:0]  got_strobes;
    logic [15:0] exp_plus;
    exp_strobes = 5'b0;
    if (m_run) exp_strobes[m_ph-1] = 1'b1;
    got_strobes = {p5, p4, p3, p2, p1};
    exp_plus = m_pc + 16'd1;
    checks++;
    assert (pc_to_memory === m_pc) else begin
      failures++;
      $error("FAIL %s pc_to_memory got=%h exp=%h", tag, pc_to_memory, m_pc);
    end
    checks++;
    assert (pc_plus_one === exp_plus) else begin
      failures++;
      $error("FAIL %s pc_plus_one got=%h exp=%h", tag, pc_plus_one, exp_plus);
    end
    checks++;
    assert (got_strobes === exp_strobes) else begin
      failures++;
      $error("FAIL %s strobes got=%b exp=%b", tag, got_strobes, exp_strobes);
    end
    checks++;
    assert (running === m_run) else begin
      failures++;
      $error("FAIL %s running got=%b exp=%b", tag, running, m_run);
    end
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, check.
  task automatic step(input string tag, input bit ex, input bit hr,
                      input bit bt, input logic [15:0] tgt);
    @(negedge clock);
    exec          = ex;
    halt_req      = hr;
    branch_taken  = bt;
    branch_target = tgt;
    @(posedge clock);
    #1;
    if (!m_run) begin
      if (ex) begin
        m_run = 1'b1;
        m_ph  = 1;
      end
    end else if (m_ph == 5) begin
      m_pc = bt ? tgt : m_pc + 16'd1;
      if (hr) begin
        m_run = 1'b0;
        m_ph  = 0;
      end else begin
        m_ph = 1;
      end
    end else begin
      m_ph = m_ph + 1;
    end
    check(tag);
  endtask

  // Idle clocks until the model says the current cycle is phase ph.
  task automatic run_to(input string tag, input int ph);
    int n;
    n = 0;
    while (!(m_run && m_ph == ph) && n < 12) begin
      step(tag, 1'b0, 1'b0, 1'b0, 16'h0);
      n++;
    end
    checks++;
    assert (m_run && m_ph == ph) else begin
      failures++;
      $error("FAIL %s run_to timeout got_ph=%0d exp_ph=%0d", tag, m_ph, ph);
    end
  endtask

  initial begin
    reset         = 1'b1;
    exec          = 1'b0;
    halt_req      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset");
    @(negedge clock);
    reset = 1'b0;

    // idle without exec
    step("idle", 1'b0, 1'b0, 1'b0, 16'h0);
    step("idle", 1'b0, 1'b1, 1'b1, 16'h5555);

    // first instruction: p1..p5 in order, then PC advances
    step("start", 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) step("phases", 1'b0, 1'b0, 1'b0, 16'h0);
    step("pc_adv", 1'b0, 1'b0, 1'b0, 16'h0);

    // sequential run, exec ignored in RUN
    for (int i = 0; i < 10; i++) step("seq", 1'b1, 1'b0, 1'b0, 16'h0);

    // branch in p5
    run_to("br_p5", 5);
    step("br_p5", 1'b0, 1'b0, 1'b1, 16'h0040);

    // branch and halt in p3 are ignored
    run_to("br_p3", 3);
    step("br_p3", 1'b0, 1'b1, 1'b1, 16'h1234);
    run_to("br_p3_end", 5);
    step("br_p3_end", 1'b0, 1'b0, 1'b0, 16'h0);

    // wraparound at all-ones
    run_to("wrap", 5);
    step("wrap", 1'b0, 1'b0, 1'b1, 16'hFFFF);
    run_to("wrap", 5);
    step("wrap", 1'b0, 1'b0, 1'b0, 16'h0);

    // halt together with branch, then restart with a pulse
    run_to("halt_br", 5);
    step("halt_br", 1'b0, 1'b1, 1'b1, 16'h0010);
    step("halt_idle", 1'b0, 1'b0, 1'b0, 16'h0);
    step("restart", 1'b1, 1'b0, 1'b0, 16'h0);

    // halt with exec held high re-enters RUN immediately
    run_to("halt_exec", 5);
    step("halt_exec", 1'b1, 1'b1, 1'b0, 16'h0);
    step("halt_exec", 1'b1, 1'b0, 1'b0, 16'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0), 16'($urandom));
    end

    // asynchronous reset mid-p3 with PC = 5
    if (!m_run) step("pre_rst", 1'b1, 1'b0, 1'b0, 16'h0);
    run_to("pc5", 5);
    step("pc5", 1'b0, 1'b0, 1'b1, 16'h0005);
    run_to("mid_p3", 3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst");
    @(posedge clock);
    #1;
    check("rst_hold");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 1'b1, 1'b1, 16'h7777);
    step("post_rst_go", 1'b1, 1'b0, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
